// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory stage retiring ALU results and doing LW/SW over a req/ack port with misalign/timeout faults
module mem_stage_lsu #(
  parameter int DBITS = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             agex_valid,
  input  logic [1:0]       agex_op,
  input  logic [DBITS-1:0] agex_pc,
  input  logic             agex_wr_reg,
  input  logic [4:0]       agex_reg_dest,
  input  logic [DBITS-1:0] agex_result,
  input  logic [DBITS-1:0] agex_mem_addr,
  output logic             mem_stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DBITS-1:0] dmem_addr,
  output logic [DBITS-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DBITS-1:0] dmem_rdata,
  output logic             wb_valid,
  output logic [DBITS-1:0] wb_pc,
  output logic             wb_wr_reg,
  output logic [4:0]       wb_reg_dest,
  output logic [DBITS-1:0] wb_data,
  output logic [1:0]       wb_fault,
  output logic             fwd_pending,
  output logic [4:0]       fwd_reg_dest
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nx;
  logic [CW-1:0]    cnt;
  logic             cap_lw, cap_wr;
  logic [4:0]       cap_dest;
  logic [DBITS-1:0] cap_pc;
  logic accept, is_mem, misalign, go_access, in_access, timed_out;
  assign accept    = (state == IDLE) && agex_valid;
  assign is_mem    = (agex_op == 2'b01) || (agex_op == 2'b10);
  assign misalign  = agex_mem_addr[1:0] != 2'b00;
  assign go_access = accept && is_mem && !misalign;
  assign in_access = state == ACCESS;
  assign timed_out = in_access && !dmem_ack && (cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = go_access ? ACCESS : IDLE;
    else state_nx = (dmem_ack || timed_out) ? IDLE : ACCESS;
  end
  always_comb begin
    mem_stall    = in_access;
    fwd_pending  = in_access && cap_lw && cap_wr;
    fwd_reg_dest = fwd_pending ? cap_dest : 5'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      cap_lw      <= 1'b0;
      cap_wr      <= 1'b0;
      cap_dest    <= '0;
      cap_pc      <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_pc       <= '0;
      wb_wr_reg   <= 1'b0;
      wb_reg_dest <= '0;
      wb_data     <= '0;
      wb_fault    <= 2'b00;
    end else begin
      wb_valid <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid    <= 1'b1;
        wb_pc       <= agex_pc;
        wb_wr_reg   <= agex_wr_reg;
        wb_reg_dest <= agex_reg_dest;
        wb_data     <= agex_result;
        wb_fault    <= 2'b00;
      end else if (accept && misalign) begin
        wb_valid    <= 1'b1;
        wb_pc       <= agex_pc;
        wb_wr_reg   <= 1'b0;
        wb_reg_dest <= agex_reg_dest;
        wb_data     <= agex_result;
        wb_fault    <= 2'b01;
      end else if (go_access) begin
        cnt        <= '0;
        cap_lw     <= agex_op == 2'b01;
        cap_wr     <= agex_wr_reg;
        cap_dest   <= agex_reg_dest;
        cap_pc     <= agex_pc;
        dmem_req   <= 1'b1;
        dmem_we    <= agex_op == 2'b10;
        dmem_addr  <= {agex_mem_addr[DBITS-1:2], 2'b00};
        dmem_wdata <= agex_result;
      end
      // ack outranks a timeout landing on the same cycle
      if (in_access && dmem_ack) begin
        dmem_req    <= 1'b0;
        wb_valid    <= 1'b1;
        wb_pc       <= cap_pc;
        wb_wr_reg   <= cap_lw && cap_wr;
        wb_reg_dest <= cap_dest;
        wb_data     <= cap_lw ? dmem_rdata : dmem_wdata;
        wb_fault    <= 2'b00;
      end else if (timed_out) begin
        dmem_req    <= 1'b0;
        wb_valid    <= 1'b1;
        wb_pc       <= cap_pc;
        wb_wr_reg   <= 1'b0;
        wb_reg_dest <= cap_dest;
        wb_fault    <= 2'b10;
      end else if (in_access) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
  logic        clk = 0, reset = 1;
  logic        agex_valid = 0, agex_wr_reg = 0, dmem_ack = 0;
  logic [1:0]  agex_op = 0;
  logic [31:0] agex_pc = 0, agex_result = 0, agex_mem_addr = 0, dmem_rdata = 0;
  logic [4:0]  agex_reg_dest = 0;
  logic        mem_stall, dmem_req, dmem_we, wb_valid, wb_wr_reg, fwd_pending;
  logic [31:0] dmem_addr, dmem_wdata, wb_pc, wb_data;
  logic [4:0]  wb_reg_dest, fwd_reg_dest;
  logic [1:0]  wb_fault;
  int checks = 0, errors = 0;
  mem_stage_lsu #(.DBITS(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .agex_valid(agex_valid), .agex_op(agex_op),
    .agex_pc(agex_pc), .agex_wr_reg(agex_wr_reg), .agex_reg_dest(agex_reg_dest),
    .agex_result(agex_result), .agex_mem_addr(agex_mem_addr), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_wr_reg(wb_wr_reg), .wb_reg_dest(wb_reg_dest), .wb_data(wb_data), .wb_fault(wb_fault),
    .fwd_pending(fwd_pending), .fwd_reg_dest(fwd_reg_dest)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] res,
                       input logic [31:0] addr, input logic [4:0] dest, input logic wr);
    agex_valid = 1; agex_op = op; agex_pc = pc; agex_result = res;
    agex_mem_addr = addr; agex_reg_dest = dest; agex_wr_reg = wr;
  endtask
  task automatic test_reset();
    reset = 1;
    step();
    step();
    reset = 0;
    checks++;
    if ({mem_stall, dmem_req, dmem_we, wb_valid, wb_wr_reg, fwd_pending} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000", {mem_stall, dmem_req, dmem_we, wb_valid, wb_wr_reg, fwd_pending});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, wb_pc, wb_data, wb_reg_dest, fwd_reg_dest, wb_fault} !== '0) begin
      errors++; $display("FAIL reset_buses not all zero addr=%h wdata=%h data=%h", dmem_addr, dmem_wdata, wb_data);
    end
  endtask
  task automatic test_alu();
    issue(2'b00, 32'h40, 32'h1234, 32'h0, 5'd5, 1);
    checks++;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", mem_stall); end
    step();
    agex_valid = 0;
    checks++;
    if ({wb_valid, wb_wr_reg, wb_reg_dest, wb_data, wb_fault, wb_pc, mem_stall} !== {1'b1, 1'b1, 5'd5, 32'h1234, 2'b00, 32'h40, 1'b0}) begin
      errors++; $display("FAIL alu_retire got v=%b wr=%b d=%0d data=%h f=%b pc=%h st=%b want v=1 wr=1 d=5 data=1234 f=00 pc=40 st=0",
                         wb_valid, wb_wr_reg, wb_reg_dest, wb_data, wb_fault, wb_pc, mem_stall);
    end
    step();
    checks++;
    if ({wb_valid, wb_data} !== {1'b0, 32'h1234}) begin
      errors++; $display("FAIL alu_hold got v=%b data=%h want v=0 data=1234", wb_valid, wb_data);
    end
  endtask
  task automatic test_lw();
    int req_cycles = 0;
    issue(2'b01, 32'h44, 32'h0, 32'h100, 5'd7, 1);
    step();
    agex_valid = 0;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, mem_stall, fwd_pending, fwd_reg_dest, wb_valid} !== {1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 5'd7, 1'b0}) begin
      errors++; $display("FAIL lw_access got req=%b we=%b addr=%h st=%b fp=%b fd=%0d v=%b want 1 0 100 1 1 7 0",
                         dmem_req, dmem_we, dmem_addr, mem_stall, fwd_pending, fwd_reg_dest, wb_valid);
    end
    for (int i = 0; i < 3; i++) begin
      if (dmem_req) req_cycles++;
      if (i == 2) begin dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; end
      step();
    end
    dmem_ack = 0;
    checks++;
    if (req_cycles !== 3) begin errors++; $display("FAIL lw_req_cycles got %0d want 3", req_cycles); end
    checks++;
    if ({wb_valid, wb_data, wb_wr_reg, wb_reg_dest, wb_fault, wb_pc} !== {1'b1, 32'hDEADBEEF, 1'b1, 5'd7, 2'b00, 32'h44}) begin
      errors++; $display("FAIL lw_retire got v=%b data=%h wr=%b d=%0d f=%b pc=%h want 1 deadbeef 1 7 00 44",
                         wb_valid, wb_data, wb_wr_reg, wb_reg_dest, wb_fault, wb_pc);
    end
    checks++;
    if ({dmem_req, mem_stall, fwd_pending, fwd_reg_dest} !== 8'b0) begin
      errors++; $display("FAIL lw_release got req=%b st=%b fp=%b fd=%0d want all 0", dmem_req, mem_stall, fwd_pending, fwd_reg_dest);
    end
  endtask
  task automatic test_back_to_back();
    issue(2'b10, 32'h48, 32'h55, 32'h204, 5'd3, 1);
    step();
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, fwd_pending, mem_stall} !== {1'b1, 1'b1, 32'h204, 32'h55, 1'b0, 1'b1}) begin
      errors++; $display("FAIL sw_access got req=%b we=%b addr=%h wdata=%h fp=%b st=%b want 1 1 204 55 0 1",
                         dmem_req, dmem_we, dmem_addr, dmem_wdata, fwd_pending, mem_stall);
    end
    issue(2'b00, 32'h4C, 32'h77, 32'h0, 5'd2, 1);
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    checks++;
    if ({wb_valid, wb_wr_reg, wb_fault, wb_data, dmem_req, mem_stall} !== {1'b1, 1'b0, 2'b00, 32'h55, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sw_retire got v=%b wr=%b f=%b data=%h req=%b st=%b want 1 0 00 55 0 0",
                         wb_valid, wb_wr_reg, wb_fault, wb_data, dmem_req, mem_stall);
    end
    step();
    agex_valid = 0;
    checks++;
    if ({wb_valid, wb_data, wb_pc, wb_wr_reg} !== {1'b1, 32'h77, 32'h4C, 1'b1}) begin
      errors++; $display("FAIL bubble_next got v=%b data=%h pc=%h wr=%b want 1 77 4c 1", wb_valid, wb_data, wb_pc, wb_wr_reg);
    end
  endtask
  task automatic test_misalign();
    issue(2'b01, 32'h50, 32'h0, 32'h102, 5'd6, 1);
    step();
    agex_valid = 0;
    checks++;
    if ({dmem_req, wb_valid, wb_fault, wb_wr_reg, mem_stall} !== {1'b0, 1'b1, 2'b01, 1'b0, 1'b0}) begin
      errors++; $display("FAIL misalign got req=%b v=%b f=%b wr=%b st=%b want 0 1 01 0 0", dmem_req, wb_valid, wb_fault, wb_wr_reg, mem_stall);
    end
  endtask
  task automatic test_timeout();
    int req_cycles = 0;
    issue(2'b01, 32'h54, 32'h0, 32'h300, 5'd9, 1);
    step();
    agex_valid = 0;
    while (dmem_req && req_cycles < 40) begin
      req_cycles++;
      step();
    end
    checks++;
    if (req_cycles !== 16) begin errors++; $display("FAIL timeout_cycles got %0d want 16", req_cycles); end
    checks++;
    if ({wb_valid, wb_fault, wb_wr_reg, wb_reg_dest} !== {1'b1, 2'b10, 1'b0, 5'd9}) begin
      errors++; $display("FAIL timeout_retire got v=%b f=%b wr=%b d=%0d want 1 10 0 9", wb_valid, wb_fault, wb_wr_reg, wb_reg_dest);
    end
    step();
    step();
    dmem_ack = 1;
    dmem_rdata = 32'hBAD0BAD0;
    step();
    dmem_ack = 0;
    checks++;
    if ({wb_valid, dmem_req, mem_stall} !== 3'b000) begin
      errors++; $display("FAIL late_ack got v=%b req=%b st=%b want 000", wb_valid, dmem_req, mem_stall);
    end
  endtask
  task automatic test_ack_at_timeout();
    issue(2'b01, 32'h58, 32'h0, 32'h310, 5'd11, 1);
    step();
    agex_valid = 0;
    for (int i = 0; i < 15; i++) step();
    dmem_ack = 1;
    dmem_rdata = 32'hCAFEF00D;
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL ack_edge_req got %b want 1", dmem_req); end
    step();
    dmem_ack = 0;
    checks++;
    if ({wb_valid, wb_fault, wb_data, wb_wr_reg} !== {1'b1, 2'b00, 32'hCAFEF00D, 1'b1}) begin
      errors++; $display("FAIL ack_wins got v=%b f=%b data=%h wr=%b want 1 00 cafef00d 1", wb_valid, wb_fault, wb_data, wb_wr_reg);
    end
  endtask
  task automatic test_reset_access();
    issue(2'b01, 32'h60, 32'h0, 32'h400, 5'd4, 1);
    step();
    agex_valid = 0;
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    checks++;
    if ({dmem_req, mem_stall, fwd_pending, fwd_reg_dest, wb_valid, wb_data, wb_fault, dmem_addr} !== '0) begin
      errors++; $display("FAIL reset_access got req=%b st=%b fp=%b v=%b data=%h f=%b addr=%h want all 0",
                         dmem_req, mem_stall, fwd_pending, wb_valid, wb_data, wb_fault, dmem_addr);
    end
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    checks++;
    if ({wb_valid, dmem_req} !== 2'b00) begin
      errors++; $display("FAIL ack_after_reset got v=%b req=%b want 00", wb_valid, dmem_req);
    end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_back_to_back();
    test_misalign();
    test_timeout();
    test_ack_at_timeout();
    test_reset_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
